// File: rtl/mult_sched.sv
// Round-robin sequencer sharing one unsigned array multiplier between two requesters.
// Signed operands are sent as magnitudes; the sign is restored on the product after the settle window.
module mult_sched #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 sgn0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  input  logic                 sgn1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id,
  output logic [2*WIDTH-1:0]   y,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_y
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               last_served;
  logic               neg_flag;

  logic               take;
  logic               win1;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_sgn;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sel_neg;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win1    = req1 && (!req0 || !last_served);
    take    = (state == IDLE) && !rst && (req0 || req1);
    gnt0    = take && !win1;
    gnt1    = take && win1;
    sel_a   = win1 ? a1 : a0;
    sel_b   = win1 ? b1 : b0;
    sel_sgn = win1 ? sgn1 : sgn0;
    mag_a   = (sel_sgn && sel_a[WIDTH-1]) ? -sel_a : sel_a;
    mag_b   = (sel_sgn && sel_b[WIDTH-1]) ? -sel_b : sel_b;
    sel_neg = sel_sgn && (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_served <= 1'b1;
      neg_flag    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      y           <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            mul_a    <= mag_a;
            mul_b    <= mag_b;
            neg_flag <= sel_neg;
            done_id  <= win1;
            cnt      <= 4'(SETTLE_CYCLES - 1);
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state <= FIN;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        FIN: begin
          y           <= neg_flag ? -mul_y : mul_y;
          done        <= 1'b1;
          last_served <= done_id;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: transaction-level reference model checked every cycle,
// plus directed corner, contention, back-to-back and reset-abort scenarios, then random traffic.
module tb_mult_sched;

  localparam int unsigned W = 32;
  localparam int unsigned S = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, sgn0, sgn1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          gnt0, gnt1, busy, done, done_id;
  logic [2*W-1:0] y, mul_y;
  logic [W-1:0]  mul_a, mul_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_sched #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .sgn0(sgn0),
    .req1(req1), .a1(a1), .b1(b1), .sgn1(sgn1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .y(y), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y)
  );

  // Array model: the product is only correct once its inputs have been stable long enough.
  logic [W-1:0] pa = '0;
  logic [W-1:0] pb = '0;
  int unsigned  stable = 0;
  logic [2*W-1:0] raw_p;
  assign raw_p = {32'b0, mul_a} * {32'b0, mul_b};
  assign mul_y = (mul_a == pa && mul_b == pb && stable >= S - 1) ? raw_p : ~raw_p;
  always @(posedge clk) begin
    pa <= mul_a;
    pb <= mul_b;
    if (mul_a != pa || mul_b != pb) stable <= 0;
    else if (stable < 100) stable <= stable + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
    longint x;
    x = s ? longint'($signed(v)) : longint'({32'b0, v});
    if (x < 0) x = -x;
    return x[W-1:0];
  endfunction

  function automatic logic [63:0] prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[W-1]}}, a} : {32'b0, a};
    eb = s ? {{32{b[W-1]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Reference model: one transaction in flight, completes S+2 cycles after its grant.
  bit          m_act  = 0;
  int          m_left = 0;
  logic        m_last = 1'b1;
  logic        m_id   = 1'b0;
  logic [W-1:0] m_ma  = '0;
  logic [W-1:0] m_mb  = '0;
  logic [63:0] m_cy   = '0;
  logic [63:0] m_y    = '0;

  always @(negedge clk) begin
    logic e_done, e_g0, e_g1;
    e_done = 1'b0;
    if (m_act) begin
      m_left--;
      if (m_left == 0) begin
        e_done = 1'b1;
        m_act  = 0;
        m_y    = m_cy;
        m_last = m_id;
      end
    end
    e_g0 = !rst && !m_act && req0 && (!req1 || m_last);
    e_g1 = !rst && !m_act && req1 && !e_g0;
    check("gnt0", 64'(gnt0), 64'(e_g0));
    check("gnt1", 64'(gnt1), 64'(e_g1));
    check("busy", 64'(busy), 64'(m_act));
    check("done", 64'(done), 64'(e_done));
    check("done_id", 64'(done_id), 64'(m_id));
    check("y", y, m_y);
    check("mul_a", 64'(mul_a), 64'(m_ma));
    check("mul_b", 64'(mul_b), 64'(m_mb));
    if (rst) begin
      m_act = 0; m_left = 0; m_last = 1'b1; m_id = 1'b0;
      m_ma = '0; m_mb = '0; m_cy = '0; m_y = '0;
    end else if (e_g0 || e_g1) begin
      m_act  = 1;
      m_left = S + 2;
      m_id   = e_g1;
      m_ma   = e_g1 ? mag(a1, sgn1) : mag(a0, sgn0);
      m_mb   = e_g1 ? mag(b1, sgn1) : mag(b0, sgn0);
      m_cy   = e_g1 ? prod(a1, b1, sgn1) : prod(a0, b0, sgn0);
      if ((e_g1 ? sgn1 : sgn0) && m_cy[63] == 1'b0 && m_cy != 0 &&
          ((e_g1 ? a1[W-1] ^ b1[W-1] : a0[W-1] ^ b0[W-1]))) m_cy = m_cy;
    end
  end

  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [63:0] ey, input logic [W-1:0] ema, input logic [W-1:0] emb);
    bit got;
    int lat;
    got = 0;
    @(posedge clk); #1;
    if (id) begin req1 = 1; a1 = a; b1 = b; sgn1 = s; end
    else    begin req0 = 1; a0 = a; b0 = b; sgn0 = s; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (id ? gnt1 : gnt0) begin got = 1; break; end
    end
    check("op_grant", 64'(got), 64'd1);
    @(posedge clk); #1;
    if (id) req1 = 0; else req0 = 0;
    @(negedge clk);
    check("op_mul_a", 64'(mul_a), 64'(ema));
    check("op_mul_b", 64'(mul_b), 64'(emb));
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("op_latency", 64'(lat), 64'd4);
    check("op_y", y, ey);
    check("op_done_id", 64'(done_id), 64'(id));
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ng, nd, cyc;
    bit gid [4];
    int gcyc [4];
    logic [63:0] dy [3];
    bit got, g0, g1;

    // Contention: both requesters held from reset.
    rst = 1;
    req0 = 1; a0 = 32'd3; b0 = 32'd4; sgn0 = 0;
    req1 = 1; a1 = 32'hFFFF_FFFE; b1 = 32'd6; sgn1 = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    ng = 0; nd = 0; cyc = 0;
    while (ng < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done && nd < 3) begin dy[nd] = y; nd++; end
      if (gnt0 || gnt1) begin gid[ng] = gnt1; gcyc[ng] = cyc; ng++; end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    check("cont_ngrants", 64'(ng), 64'd4);
    check("cont_first_cycle", 64'(gcyc[0]), 64'd1);
    for (int i = 0; i < 4; i++) check("cont_order", 64'(gid[i]), 64'(i % 2));
    for (int i = 1; i < 4; i++) check("cont_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd4);
    check("cont_ndone", 64'(nd), 64'd3);
    check("cont_y0", dy[0], 64'd12);
    check("cont_y1", dy[1], 64'hFFFF_FFFF_FFFF_FFF4);
    check("cont_y2", dy[2], 64'd12);
    repeat (6) @(posedge clk);

    // Directed values and corners.
    do_op(0, 32'd5, 32'd7, 0, 64'd35, 32'd5, 32'd7);
    do_op(0, 32'hFFFF_FFFB, 32'd9, 1, 64'hFFFF_FFFF_FFFF_FFD3, 32'd5, 32'd9);
    do_op(0, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, 32'h8000_0000, 32'h8000_0000);
    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(0, 32'd0, 32'hFFFF_FFFF, 1, 64'd0, 32'd0, 32'd1);
    do_op(1, 32'd7, 32'hFFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFEB, 32'd7, 32'd3);

    // Reset during RUN with the request still held.
    @(posedge clk); #1;
    req0 = 1; a0 = 32'd10; b0 = 32'd11; sgn0 = 0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt0) begin got = 1; break; end
    end
    check("rr_grant", 64'(got), 64'd1);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("rr_busy_before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_no_gnt_in_rst", 64'(gnt0), 64'd0);
    check("rr_y_zero", y, 64'd0);
    check("rr_mul_a_zero", 64'(mul_a), 64'd0);
    check("rr_busy_zero", 64'(busy), 64'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rr_regrant", 64'(gnt0), 64'd1);
    @(posedge clk); #1 req0 = 0;
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    check("rr_done_y", y, 64'd110);

    // Random traffic with occasional withdrawals and resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      g0 = gnt0; g1 = gnt1;
      @(posedge clk); #1;
      if (g0 || (req0 && $urandom_range(0, 19) == 0)) req0 = 0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; a0 = rnd_op(); b0 = rnd_op(); sgn0 = 1'($urandom);
      end
      if (g1 || (req1 && $urandom_range(0, 19) == 0)) req1 = 0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; a1 = rnd_op(); b1 = rnd_op(); sgn1 = 1'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 0; req0 = 0; req1 = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
# mult_sched

Sequencing and sharing controller for the 32x32 combinational array multiplier in the RISC datapath. Two requesters (e.g. execute-stage MUL and a multi-cycle MULH/MAC path) share one multiplier instance through round-robin arbitration. The controller latches operands and converts signed operands to magnitudes for the unsigned array. It holds the inputs stable for a programmable settle window, then applies the sign correction and returns a registered 64-bit product with a one-cycle done pulse.

## Interface
- WIDTH, 32: operand width; product is 2*WIDTH.
- SETTLE_CYCLES, 2: cycles the array's inputs are held before the product is sampled; legal range 1..15.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  level request from requester 0; held with operands stable until gnt0.
- a0, b0  in  WIDTH  requester 0 operands.
- sgn0  in  1  1 = signed (two's complement), 0 = unsigned, requester 0.
- req1, a1, b1, sgn1  in  1/WIDTH/WIDTH/1  same for requester 1.
- gnt0, gnt1  out  1  one-cycle accept pulse; operands sampled on the edge ending this cycle.
- busy  out  1  high while a multiply is in flight (RUN or FIN).
- done  out  1  one-cycle pulse, y valid.
- done_id  out  1  index of the requester whose result is on y.
- y  out  2*WIDTH  registered product, held until next done.
- mul_a, mul_b  out  WIDTH  registered magnitudes to the array multiplier inputs.
- mul_y  in  2*WIDTH  array multiplier product.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: if any req, assert the winning gnt combinationally. On the edge, latch operands into mul_a/mul_b, latch neg_flag and done_id, load counter = SETTLE_CYCLES-1, go RUN.
- Arbitration: a single request wins. If both request, the one not served last wins. The last_served register resets to 1, so req0 wins the first tie.
- Magnitudes: if sgn=1 and operand MSB=1, drive the two's-complement negation; otherwise pass the operand through. Magnitude of 0x80000000 is 0x80000000 (fits unsigned).
- neg_flag = sgn & (a[MSB] ^ b[MSB]).
- RUN: counter decrements each cycle; at 0 go FIN. mul_a/mul_b are constant throughout RUN and FIN.
- FIN: on the edge, y <= neg_flag ? -mul_y (2*WIDTH-bit two's complement) : mul_y. Set done=1, update last_served, go IDLE.
- done is high in the first IDLE cycle after FIN. A new gnt may be issued in that same cycle.
- gnt is never asserted outside IDLE. Requests arriving while busy wait; request lines are not latched.
- A requester dropping req before gnt is legal; nothing is recorded.

## Timing
- Reset values: state IDLE; gnt0=gnt1=0; busy=0; done=0; done_id=0; y=0; mul_a=mul_b=0; counter=0; last_served=1.
- Grant in cycle T, then RUN in T+1..T+SETTLE_CYCLES, then FIN in T+SETTLE_CYCLES+1, then done and y valid in T+SETTLE_CYCLES+2.
- Grant-to-done latency is SETTLE_CYCLES+2 cycles. Back-to-back throughput is one product per SETTLE_CYCLES+2 cycles.
- busy is high in RUN and FIN, and low in the done cycle.
- Reset mid-RUN or mid-FIN: abort with no done pulse, all outputs return to reset values next cycle, and the pending request is re-granted after reset releases.
- Simultaneous rst and req: reset wins, no gnt.

## Test plan
- Unsigned 5*7 on req0, SETTLE_CYCLES=2 -> gnt0 one cycle; done 4 cycles later with y=64'd35, done_id=0.
- Signed -5*9 (a0=0xFFFFFFFB, b0=9, sgn0=1) -> mul_a=5, mul_b=9; y=0xFFFFFFFFFFFFFFD3.
- Corners: signed 0x80000000*0x80000000 -> y=0x4000000000000000. Unsigned 0xFFFFFFFF*0xFFFFFFFF -> y=0xFFFFFFFE00000001. Signed 0*-1 -> y=0.
- Contention: req0 and req1 held high from reset with distinct operands -> grants go 0,1,0,1 in order. Each done_id matches its grant. No grant occurs while busy.
- Back-to-back: a new request in the done cycle is granted that same cycle. The previous y holds until the next done.
- Reset asserted during RUN -> no done pulse, outputs are zero next cycle, and the held request is re-granted on the first cycle after rst deasserts.
